// File: rtl/controller_pkg.sv
// Shared VeriRISC types: opcode and controller state encodings.
// Also used by the ALU and the instruction register.
package typedefs;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [OPCODE_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [STATE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

endpackage

// File: rtl/controller.sv
// VeriRISC instruction sequencer: eight-phase cycle per instruction with
// opcode-decoded control strobes and a sticky halt.
module controller
    import typedefs::*;
(
    input  logic    clk,
    input  logic    rst_,
    input  opcode_t opcode,
    input  logic    zero,
    output logic    sel,
    output logic    mem_rd,
    output logic    load_ir,
    output logic    halt,
    output logic    inc_pc,
    output logic    load_ac,
    output logic    load_pc,
    output logic    mem_wr,
    output logic    data_e
);

    state_t state;
    state_t next_state;
    logic   halted;
    logic   halted_next;
    logic   aluop;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else begin
            state  <= next_state;
            halted <= halted_next;
        end
    end

    // Next-state and strobe decode; a halted CPU holds state and shows only halt.
    always_comb begin
        next_state  = state;
        halted_next = halted;
        sel         = 1'b0;
        mem_rd      = 1'b0;
        load_ir     = 1'b0;
        halt        = 1'b0;
        inc_pc      = 1'b0;
        load_ac     = 1'b0;
        load_pc     = 1'b0;
        mem_wr      = 1'b0;
        data_e      = 1'b0;
        aluop       = (opcode == ADD) || (opcode == AND) ||
                      (opcode == XOR) || (opcode == LDA);

        if (halted) begin
            halt = 1'b1;
        end else begin
            unique case (state)
                INST_ADDR: begin
                    sel        = 1'b1;
                    next_state = INST_FETCH;
                end
                INST_FETCH: begin
                    sel        = 1'b1;
                    mem_rd     = 1'b1;
                    next_state = INST_LOAD;
                end
                INST_LOAD: begin
                    sel        = 1'b1;
                    mem_rd     = 1'b1;
                    load_ir    = 1'b1;
                    next_state = IDLE;
                end
                IDLE: begin
                    sel        = 1'b1;
                    mem_rd     = 1'b1;
                    load_ir    = 1'b1;
                    next_state = OP_ADDR;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                    if (opcode == HLT) begin
                        halted_next = 1'b1;
                    end else begin
                        next_state = OP_FETCH;
                    end
                end
                OP_FETCH: begin
                    mem_rd     = aluop;
                    next_state = ALU_OP;
                end
                ALU_OP: begin
                    mem_rd     = aluop;
                    inc_pc     = (opcode == SKZ) && zero;
                    load_pc    = (opcode == JMP);
                    data_e     = (opcode == STO);
                    next_state = STORE;
                end
                STORE: begin
                    mem_rd     = aluop;
                    load_ac    = aluop;
                    inc_pc     = (opcode == JMP);
                    load_pc    = (opcode == JMP);
                    data_e     = (opcode == STO);
                    mem_wr     = (opcode == STO);
                    next_state = INST_ADDR;
                end
                default: begin
                    next_state = INST_ADDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: phase/halt model compared every cycle,
// plus directed literal expectations at key phases.
module tb_controller;
    import typedefs::*;

    logic    clk = 1'b0;
    logic    rst_ = 1'b0;
    opcode_t opcode = ADD;
    logic    zero = 1'b0;
    logic    sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e;

    controller dut (
        .clk     (clk),
        .rst_    (rst_),
        .opcode  (opcode),
        .zero    (zero),
        .sel     (sel),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .halt    (halt),
        .inc_pc  (inc_pc),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr),
        .data_e  (data_e)
    );

    always #5 clk = ~clk;

    // Model: phase number 0..7 within the instruction plus a halted flag.
    int m_ph   = 0;
    bit m_halt = 1'b0;

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_ph   <= 0;
            m_halt <= 1'b0;
        end else if (!m_halt) begin
            if (m_ph == 4 && opcode == HLT) m_halt <= 1'b1;
            else                            m_ph   <= (m_ph + 1) % 8;
        end
    end

    // Order: {sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e}
    function automatic logic [8:0] model_out(int ph, logic [2:0] op, logic z, bit hl);
        logic alu, is_sto, is_jmp;
        logic [8:0] v;
        if (hl) return 9'b000100000;
        alu    = (op >= 3'd2) && (op <= 3'd5);
        is_sto = (op == 3'd6);
        is_jmp = (op == 3'd7);
        v[8] = (ph < 4);
        v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        v[6] = (ph == 2 || ph == 3);
        v[5] = (ph == 4 && op == 3'd0);
        v[4] = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && is_jmp);
        v[3] = (ph == 7 && alu);
        v[2] = (ph == 6 || ph == 7) && is_jmp;
        v[1] = (ph == 7 && is_sto);
        v[0] = (ph == 6 || ph == 7) && is_sto;
        return v;
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    // Literal expectations posted by the stimulus, consumed by the compare process.
    int          lit_seq = 0;
    int          lit_seen = 0;
    logic [8:0]  lit_exp = '0;
    string       lit_name = "";
    int          tmo_cnt = 0;
    int          tmo_seen = 0;

    wire [8:0] dut_out = {sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e};

    always begin
        logic [8:0] e;
        @(negedge clk or negedge rst_);
        #1;
        e = model_out(m_ph, 3'(opcode), zero, m_halt);
        n_checks++;
        if (dut_out !== e) begin
            n_errors++;
            $display("FAIL model phase=%0d halted=%0d op=%0d zero=%0d: got %b expected %b",
                     m_ph, m_halt, 3'(opcode), zero, dut_out, e);
        end
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            n_checks++;
            if (dut_out !== lit_exp) begin
                n_errors++;
                $display("FAIL %s: got %b expected %b", lit_name, dut_out, lit_exp);
            end
        end
        if (tmo_cnt != tmo_seen) begin
            tmo_seen = tmo_cnt;
            n_checks++;
            n_errors++;
            $display("FAIL phase_wait: got timeout expected phase reached");
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic post(string name, logic [8:0] exp);
        lit_name = name;
        lit_exp  = exp;
        lit_seq++;
    endtask

    task automatic go_phase(int p);
        int k = 0;
        while (m_ph != p && k < 16) begin
            step();
            k++;
        end
        if (m_ph != p) tmo_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        post("reset_hold", 9'b100000000);
        step();
        rst_ = 1'b1;

        // ADD: reaches STORE on the 8th cycle after release
        repeat (7) step();
        post("add_store", 9'b010001000);
        step();
        post("after_store", 9'b100000000);

        opcode = STO;
        go_phase(6); post("sto_alu", 9'b000000001);
        step();      post("sto_store", 9'b000000011);

        go_phase(0); opcode = SKZ; zero = 1'b1;
        go_phase(4); post("skz_op_addr", 9'b000010000);
        go_phase(6); post("skz_z1_alu", 9'b000010000);
        go_phase(0); zero = 1'b0;
        go_phase(6); post("skz_z0_alu", 9'b000000000);

        go_phase(0); opcode = JMP;
        go_phase(6); post("jmp_alu", 9'b000000100);
        step();      post("jmp_store", 9'b000010100);
        step();      post("jmp_next", 9'b100000000);

        // Sweep every non-halt opcode with both zero values
        for (int i = 1; i < 8; i++) begin
            for (int z = 0; z < 2; z++) begin
                go_phase(0);
                opcode = opcode_t'(3'(i));
                zero   = 1'(z);
                go_phase(7);
                step();
            end
        end

        go_phase(0); opcode = HLT; zero = 1'b1;
        go_phase(4); post("hlt_op_addr", 9'b000110000);
        repeat (20) step();
        post("hlt_frozen", 9'b000100000);
        step();
        post("hlt_async_reset", 9'b100000000);
        rst_ = 1'b0;
        step();
        rst_ = 1'b1;
        opcode = LDA;
        go_phase(7); post("lda_store", 9'b010001000);
        step();

        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
